complement_unit: RTL and testbench

- Registered complement unit for the 8-bit ALU datapath.
- Takes one operand per cycle and produces its one's complement (primary function), two's complement, absolute value or pass-through.
- Produces status flags alongside the result.
- Sits between the operand registers and the ALU result mux; one-cycle latency, valid-qualified.

---
 rtl/complement_unit.sv | 94 +++++++++
 tb/tb_complement_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/complement_unit.sv
// Registered complement unit: one's/two's complement, absolute value or pass-through
// of one operand per cycle, with zero/neg/ovf status and a one-cycle latency.
module complement_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic [WIDTH-1:0] b,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam logic [1:0] MODE_ONES = 2'b00;
  localparam logic [1:0] MODE_TWOS = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_ones;
  logic [WIDTH-1:0] w_twos;
  logic             w_is_most_neg;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;

  logic             r_valid;
  logic [WIDTH-1:0] r_b;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;

  assign w_ones        = ~a;
  assign w_twos        = w_ones + {{(WIDTH-1){1'b0}}, 1'b1};
  // Negating the most-negative value wraps back onto itself; that is the only overflow case.
  assign w_is_most_neg = (a == MOST_NEG);

  always_comb begin
    w_result = w_ones;
    w_ovf    = 1'b0;
    case (mode)
      MODE_ONES: begin
        w_result = w_ones;
        w_ovf    = 1'b0;
      end
      MODE_TWOS: begin
        w_result = w_twos;
        w_ovf    = w_is_most_neg;
      end
      MODE_ABS: begin
        w_result = a[WIDTH-1] ? w_twos : a;
        w_ovf    = w_is_most_neg;
      end
      MODE_PASS: begin
        w_result = a;
        w_ovf    = 1'b0;
      end
      default: begin
        w_result = w_ones;
        w_ovf    = 1'b0;
      end
    endcase
  end

  // Flags are derived from the new result so they always describe the registered b.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_b     <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_b    <= w_result;
        r_zero <= (w_result == '0);
        r_neg  <= w_result[WIDTH-1];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = r_valid;
  assign b         = r_b;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_complement_unit.sv
// Scoreboard bench for complement_unit: stimulus pushes hand-computed expected
// outputs per cycle, a monitor pops and compares them on the falling edge.
module tb_complement_unit;

  typedef struct packed {
    int         due;
    logic       vld;
    logic [7:0] b;
    logic       z;
    logic       n;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] mode;
  logic [7:0] a;
  logic       out_valid;
  logic [7:0] b;
  logic       zero;
  logic       neg;
  logic       ovf;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  complement_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .mode     (mode),
    .a        (a),
    .out_valid(out_valid),
    .b        (b),
    .zero     (zero),
    .neg      (neg),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every result that has become due after the latest rising edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      if (e.due != cyc || out_valid !== e.vld || b !== e.b || zero !== e.z ||
          neg !== e.n || ovf !== e.o) begin
        n_bad = n_bad + 1;
        $display("FAIL cyc%0d: got vld=%b b=%b z=%b n=%b o=%b, want vld=%b b=%b z=%b n=%b o=%b",
                 cyc, out_valid, b, zero, neg, ovf, e.vld, e.b, e.z, e.n, e.o);
      end else begin
        $display("ok   cyc%0d: vld=%b b=%b z=%b n=%b o=%b", cyc, out_valid, b, zero, neg, ovf);
      end
    end
  end

  // Drive one cycle of inputs and record what the outputs must show after the next edge.
  task automatic step(input logic r, input logic iv, input logic [1:0] m, input logic [7:0] av,
                      input logic ev, input logic [7:0] eb, input logic ez, input logic en,
                      input logic eo);
    exp_t e;
    rst      = r;
    in_valid = iv;
    mode     = m;
    a        = av;
    e.due = cyc + 1;
    e.vld = ev;
    e.b   = eb;
    e.z   = ez;
    e.n   = en;
    e.o   = eo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; a = 8'h00;
    @(posedge clk);
    #1;
    // Reset with a valid operand present: reset wins.
    step(1, 1, 2'b00, 8'hFF, 0, 8'h00, 0, 0, 0);
    step(1, 1, 2'b00, 8'hFF, 0, 8'h00, 0, 0, 0);
    // One's complement sweep
    step(0, 1, 2'b00, 8'b00000101, 1, 8'b11111010, 0, 1, 0);
    step(0, 1, 2'b00, 8'b00000100, 1, 8'b11111011, 0, 1, 0);
    step(0, 1, 2'b00, 8'b00010100, 1, 8'b11101011, 0, 1, 0);
    step(0, 1, 2'b00, 8'b10000101, 1, 8'b01111010, 0, 0, 0);
    step(0, 1, 2'b00, 8'b10000001, 1, 8'b01111110, 0, 0, 0);
    step(0, 1, 2'b00, 8'b10010101, 1, 8'b01101010, 0, 0, 0);
    step(0, 1, 2'b00, 8'b10010000, 1, 8'b01101111, 0, 0, 0);
    step(0, 1, 2'b00, 8'b10010001, 1, 8'b01101110, 0, 0, 0);
    step(0, 1, 2'b00, 8'b10010100, 1, 8'b01101011, 0, 0, 0);
    step(0, 1, 2'b00, 8'b11111111, 1, 8'b00000000, 1, 0, 0);
    // Two's complement
    step(0, 1, 2'b01, 8'b00000101, 1, 8'b11111011, 0, 1, 0);
    step(0, 1, 2'b01, 8'b00000000, 1, 8'b00000000, 1, 0, 0);
    step(0, 1, 2'b01, 8'b10000000, 1, 8'b10000000, 0, 1, 1);
    step(0, 1, 2'b01, 8'b11111111, 1, 8'b00000001, 0, 0, 0);
    // Absolute value
    step(0, 1, 2'b10, 8'b11111011, 1, 8'b00000101, 0, 0, 0);
    step(0, 1, 2'b10, 8'b00000111, 1, 8'b00000111, 0, 0, 0);
    step(0, 1, 2'b10, 8'b10000000, 1, 8'b10000000, 0, 1, 1);
    step(0, 1, 2'b10, 8'b00000000, 1, 8'b00000000, 1, 0, 0);
    // Pass-through, then idle cycles with a changing: b and flags hold.
    step(0, 1, 2'b11, 8'b10010101, 1, 8'b10010101, 0, 1, 0);
    step(0, 0, 2'b00, 8'b00000000, 0, 8'b10010101, 0, 1, 0);
    step(0, 0, 2'b01, 8'b10000000, 0, 8'b10010101, 0, 1, 0);
    step(0, 0, 2'b10, 8'b11111111, 0, 8'b10010101, 0, 1, 0);
    // Ovf flag holds through idle as well, then reset mid-stream discards the operand.
    step(0, 1, 2'b01, 8'b10000000, 1, 8'b10000000, 0, 1, 1);
    step(0, 0, 2'b00, 8'b00000001, 0, 8'b10000000, 0, 1, 1);
    step(1, 1, 2'b00, 8'b00000101, 0, 8'b00000000, 0, 0, 0);
    step(0, 0, 2'b00, 8'b00000101, 0, 8'b00000000, 0, 0, 0);
    step(0, 1, 2'b00, 8'b00000101, 1, 8'b11111010, 0, 1, 0);
    step(0, 1, 2'b11, 8'b00000000, 1, 8'b00000000, 1, 0, 0);
    step(0, 0, 2'b00, 8'b00000000, 0, 8'b00000000, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
